// File: rtl/vga_mem_arbiter.sv
`timescale 1ns/1ps
// Two-port Avalon-MM read arbiter: display DMA (port 0, priority) and a general
// read master (port 1) share one pipelined read port; beats are routed back by a tag FIFO.
module vga_mem_arbiter #(
    parameter int MAX_OUTST    = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [31:0]                  m0_address,
    input  logic                         m0_read,
    output logic                         m0_waitrequest,
    output logic [31:0]                  m0_readdata,
    output logic                         m0_data_valid,
    input  logic [31:0]                  m1_address,
    input  logic                         m1_read,
    output logic                         m1_waitrequest,
    output logic [31:0]                  m1_readdata,
    output logic                         m1_data_valid,
    output logic [31:0]                  down_address,
    output logic                         down_read,
    input  logic                         down_waitrequest,
    input  logic [31:0]                  down_readdata,
    input  logic                         down_data_valid,
    output logic [$clog2(MAX_OUTST):0]   outstanding,
    output logic                         err_orphan
);
    localparam int AW = $clog2(MAX_OUTST);

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    lock_state_t          state, state_next;
    logic                 lock_sel, lock_sel_next;
    logic [MAX_OUTST-1:0] tag_fifo;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic [7:0]           starve_cnt;
    logic                 full, promote, sel_valid, sel;
    logic                 accept, push, pop, has_data, head;

    assign full     = (count == (AW+1)'(MAX_OUTST));
    assign promote  = (starve_cnt >= 8'(STARVE_LIMIT)) && m1_read;
    assign has_data = (count != '0);
    assign head     = tag_fifo[rd_ptr];

    // Grant selection; a stalled transfer keeps its grant until accepted
    always_comb begin
        sel_valid = 1'b0;
        sel       = 1'b0;
        if (reset_n && !full) begin
            if (state == LOCKED) begin
                sel_valid = 1'b1;
                sel       = lock_sel;
            end else if (promote) begin
                sel_valid = 1'b1;
                sel       = 1'b1;
            end else if (m0_read) begin
                sel_valid = 1'b1;
            end else if (m1_read) begin
                sel_valid = 1'b1;
                sel       = 1'b1;
            end
        end
    end

    assign down_read      = sel_valid && (sel ? m1_read : m0_read);
    assign down_address   = (sel_valid && sel) ? m1_address : m0_address;
    assign m0_waitrequest = (sel_valid && !sel) ? down_waitrequest : 1'b1;
    assign m1_waitrequest = (sel_valid && sel)  ? down_waitrequest : 1'b1;

    assign accept = down_read && !down_waitrequest;
    assign push   = accept;
    assign pop    = down_data_valid && has_data;

    assign m0_readdata   = down_readdata;
    assign m1_readdata   = down_readdata;
    assign m0_data_valid = pop && !head;
    assign m1_data_valid = pop && head;
    assign outstanding   = count;

    always_comb begin
        state_next    = state;
        lock_sel_next = lock_sel;
        if (down_read) begin
            if (down_waitrequest) begin
                state_next    = LOCKED;
                lock_sel_next = sel;
            end else begin
                state_next    = UNLOCKED;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= UNLOCKED;
            lock_sel <= 1'b0;
        end else begin
            state    <= state_next;
            lock_sel <= lock_sel_next;
        end
    end

    // Tag FIFO and occupancy; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_fifo   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) begin
                tag_fifo[wr_ptr] <= sel;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (down_data_valid && !has_data)
                err_orphan <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            starve_cnt <= '0;
        else if (!m1_read || (accept && sel))
            starve_cnt <= '0;
        else if (starve_cnt != 8'hFF)
            starve_cnt <= starve_cnt + 1'b1;
    end
endmodule

// File: tb/tb_vga_mem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for vga_mem_arbiter with hand-computed expectations.
module tb_vga_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] m0_address, m1_address, down_address, down_readdata;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_read, m1_read, m0_waitrequest, m1_waitrequest;
    logic        m0_data_valid, m1_data_valid;
    logic        down_read, down_waitrequest, down_data_valid;
    logic [3:0]  outstanding;
    logic        err_orphan;
    int          tests = 0;
    int          fails = 0;
    int          grant_exp [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    always #5 clk = ~clk;

    vga_mem_arbiter #(.MAX_OUTST(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_data_valid(m0_data_valid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_data_valid(m1_data_valid),
        .down_address(down_address), .down_read(down_read),
        .down_waitrequest(down_waitrequest), .down_readdata(down_readdata),
        .down_data_valid(down_data_valid), .outstanding(outstanding),
        .err_orphan(err_orphan)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [31:0] a0, input logic r1,
                                 input logic [31:0] a1, input logic wr, input logic dv,
                                 input logic [31:0] rd);
        m0_read = r0; m0_address = a0; m1_read = r1; m1_address = a1;
        down_waitrequest = wr; down_data_valid = dv; down_readdata = rd;
        #2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1, 32'h10, 0, 32'h20, 0, 0, 0);
        checkOutput("rst_down_read", 32'(down_read), 0);
        checkOutput("rst_m0_wait", 32'(m0_waitrequest), 1);
        checkOutput("rst_m1_wait", 32'(m1_waitrequest), 1);
        checkOutput("rst_outst", 32'(outstanding), 0);
        checkOutput("rst_orphan", 32'(err_orphan), 0);
        applyStimulus(0, 32'h10, 0, 32'h20, 0, 0, 0);
        nextCycle();
        nextCycle();
        reset_n = 1'b1;
        nextCycle();

        // Priority with starvation promotion every fifth grant
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 32'h1000, 1, 32'h2000, 0, k != 0, 32'h0);
            checkOutput($sformatf("prio_addr%0d", k), down_address,
                        grant_exp[k] != 0 ? 32'h2000 : 32'h1000);
            checkOutput($sformatf("prio_m0wait%0d", k), 32'(m0_waitrequest),
                        grant_exp[k] != 0 ? 32'd1 : 32'd0);
            nextCycle();
        end
        checkOutput("prio_outst", 32'(outstanding), 1);
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h0);
        nextCycle();
        checkOutput("prio_drain", 32'(outstanding), 0);

        // Lock: m1 stalled three cycles, m0 arrives meanwhile
        applyStimulus(0, 32'h1111, 1, 32'h2222, 1, 0, 0);
        checkOutput("lock_addr0", down_address, 32'h2222);
        checkOutput("lock_m1wait0", 32'(m1_waitrequest), 1);
        nextCycle();
        for (int k = 1; k < 3; k++) begin
            applyStimulus(1, 32'h1111, 1, 32'h2222, 1, 0, 0);
            checkOutput($sformatf("lock_addr%0d", k), down_address, 32'h2222);
            checkOutput($sformatf("lock_m0wait%0d", k), 32'(m0_waitrequest), 1);
            nextCycle();
        end
        applyStimulus(1, 32'h1111, 1, 32'h2222, 0, 0, 0);
        checkOutput("lock_acc_addr", down_address, 32'h2222);
        checkOutput("lock_acc_m1wait", 32'(m1_waitrequest), 0);
        checkOutput("lock_acc_m0wait", 32'(m0_waitrequest), 1);
        nextCycle();
        applyStimulus(1, 32'h1111, 0, 32'h2222, 0, 0, 0);
        checkOutput("lock_next_addr", down_address, 32'h1111);
        checkOutput("lock_next_m0wait", 32'(m0_waitrequest), 0);
        nextCycle();
        checkOutput("lock_outst", 32'(outstanding), 2);
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h55);
        checkOutput("lock_ret_m1dv", 32'(m1_data_valid), 1);
        checkOutput("lock_ret_m0dv", 32'(m0_data_valid), 0);
        nextCycle();
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h66);
        checkOutput("lock_ret2_m0dv", 32'(m0_data_valid), 1);
        nextCycle();
        checkOutput("lock_drain", 32'(outstanding), 0);

        // Routing: issue m0, m1, m0 then return A, B, C
        applyStimulus(1, 32'h100, 0, 32'h200, 0, 0, 0);
        nextCycle();
        checkOutput("route_outst1", 32'(outstanding), 1);
        applyStimulus(0, 32'h100, 1, 32'h200, 0, 0, 0);
        nextCycle();
        checkOutput("route_outst2", 32'(outstanding), 2);
        applyStimulus(1, 32'h104, 0, 32'h200, 0, 0, 0);
        nextCycle();
        checkOutput("route_outst3", 32'(outstanding), 3);
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hA);
        checkOutput("route_b1_m0dv", 32'(m0_data_valid), 1);
        checkOutput("route_b1_m1dv", 32'(m1_data_valid), 0);
        checkOutput("route_b1_data", m0_readdata, 32'hA);
        nextCycle();
        checkOutput("route_outst4", 32'(outstanding), 2);
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hB);
        checkOutput("route_b2_m1dv", 32'(m1_data_valid), 1);
        checkOutput("route_b2_m0dv", 32'(m0_data_valid), 0);
        checkOutput("route_b2_data", m1_readdata, 32'hB);
        nextCycle();
        checkOutput("route_outst5", 32'(outstanding), 1);
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hC);
        checkOutput("route_b3_m0dv", 32'(m0_data_valid), 1);
        nextCycle();
        checkOutput("route_outst6", 32'(outstanding), 0);

        // Simultaneous push and pop at count 3
        applyStimulus(1, 32'h300, 0, 32'h400, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 32'h300, 1, 32'h400, 0, 0, 0);
        nextCycle();
        applyStimulus(1, 32'h304, 0, 32'h400, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 32'h404, 0, 1, 32'h1);
        checkOutput("sim_m0dv", 32'(m0_data_valid), 1);
        checkOutput("sim_m1wait", 32'(m1_waitrequest), 0);
        nextCycle();
        checkOutput("sim_outst", 32'(outstanding), 3);
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h2);
        checkOutput("sim_r1_m1dv", 32'(m1_data_valid), 1);
        nextCycle();
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h3);
        checkOutput("sim_r2_m0dv", 32'(m0_data_valid), 1);
        nextCycle();
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h4);
        checkOutput("sim_r3_m1dv", 32'(m1_data_valid), 1);
        nextCycle();
        checkOutput("sim_drain", 32'(outstanding), 0);

        // Full: eight accepted reads block further grants
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 32'h500 + 32'(k), 0, 32'h600, 0, 0, 0);
            nextCycle();
        end
        checkOutput("full_outst", 32'(outstanding), 8);
        applyStimulus(1, 32'h508, 1, 32'h600, 0, 0, 0);
        checkOutput("full_down_read", 32'(down_read), 0);
        checkOutput("full_m0wait", 32'(m0_waitrequest), 1);
        checkOutput("full_m1wait", 32'(m1_waitrequest), 1);
        nextCycle();
        applyStimulus(1, 32'h508, 0, 32'h600, 0, 1, 32'h7);
        checkOutput("full_pop_down_read", 32'(down_read), 0);
        nextCycle();
        checkOutput("full_pop_outst", 32'(outstanding), 7);
        applyStimulus(1, 32'h508, 0, 32'h600, 0, 0, 0);
        checkOutput("full_resume_read", 32'(down_read), 1);
        checkOutput("full_resume_m0wait", 32'(m0_waitrequest), 0);
        nextCycle();
        checkOutput("full_refill", 32'(outstanding), 8);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h0);
            nextCycle();
        end
        checkOutput("full_drain", 32'(outstanding), 0);

        // Orphan beat, then reset in the middle of a stalled transfer
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hDEAD);
        checkOutput("orph_m0dv", 32'(m0_data_valid), 0);
        checkOutput("orph_m1dv", 32'(m1_data_valid), 0);
        nextCycle();
        checkOutput("orph_flag", 32'(err_orphan), 1);
        checkOutput("orph_outst", 32'(outstanding), 0);
        applyStimulus(1, 32'h3000, 0, 32'h4000, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 32'h3000, 1, 32'h4000, 1, 0, 0);
        nextCycle();
        checkOutput("orph_pre_outst", 32'(outstanding), 1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("mrst_orphan", 32'(err_orphan), 0);
        checkOutput("mrst_outst", 32'(outstanding), 0);
        checkOutput("mrst_down_read", 32'(down_read), 0);
        checkOutput("mrst_m1wait", 32'(m1_waitrequest), 1);
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 0);
        nextCycle();
        reset_n = 1'b1;
        nextCycle();
        applyStimulus(1, 32'h5000, 0, 32'h4000, 0, 0, 0);
        checkOutput("post_rst_addr", down_address, 32'h5000);
        checkOutput("post_rst_m0wait", 32'(m0_waitrequest), 0);
        nextCycle();
        checkOutput("post_rst_outst", 32'(outstanding), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
